// File: rtl/hyperbus_trans_arbiter_if.sv
// Bundle of the transaction, TX and RX streams between the two channel
// controllers, the arbiter and the single HyperBus PHY.
// slave  : arbiter view.
// master : environment view (controllers + PHY).
interface hyperbus_trans_arbiter_if #(
    parameter int unsigned TRANS_SIZE = 16
);
    logic [1:0]              ch_trans_valid_i;
    logic [1:0]              ch_trans_ready_o;
    logic [63:0]             ch_trans_address_i;
    logic [3:0]              ch_trans_cs_i;
    logic [1:0]              ch_trans_write_i;
    logic [2*TRANS_SIZE-1:0] ch_trans_burst_i;
    logic [33:0]             ch_tx_data_i;
    logic [3:0]              ch_tx_strb_i;
    logic [1:0]              ch_tx_valid_i;
    logic [1:0]              ch_tx_ready_o;
    logic [16:0]             ch_rx_data_o;
    logic [1:0]              ch_rx_valid_o;
    logic [1:0]              ch_rx_ready_i;
    logic                    trans_phy_valid_o;
    logic                    trans_phy_ready_i;
    logic [31:0]             trans_phy_address_o;
    logic [1:0]              trans_phy_cs_o;
    logic                    trans_phy_write_o;
    logic [TRANS_SIZE-1:0]   trans_phy_burst_o;
    logic [16:0]             tx_phy_data_o;
    logic [1:0]              tx_phy_strb_o;
    logic                    tx_phy_valid_o;
    logic                    tx_phy_ready_i;
    logic [16:0]             rx_phy_data_i;
    logic                    rx_phy_valid_i;
    logic                    rx_phy_ready_o;
    logic                    grant_o;
    logic                    busy_o;
    logic [1:0]              error_o;

    modport slave (
        input  ch_trans_valid_i, ch_trans_address_i, ch_trans_cs_i, ch_trans_write_i,
               ch_trans_burst_i, ch_tx_data_i, ch_tx_strb_i, ch_tx_valid_i, ch_rx_ready_i,
               trans_phy_ready_i, tx_phy_ready_i, rx_phy_data_i, rx_phy_valid_i,
        output ch_trans_ready_o, ch_tx_ready_o, ch_rx_data_o, ch_rx_valid_o,
               trans_phy_valid_o, trans_phy_address_o, trans_phy_cs_o, trans_phy_write_o,
               trans_phy_burst_o, tx_phy_data_o, tx_phy_strb_o, tx_phy_valid_o,
               rx_phy_ready_o, grant_o, busy_o, error_o
    );

    modport master (
        output ch_trans_valid_i, ch_trans_address_i, ch_trans_cs_i, ch_trans_write_i,
               ch_trans_burst_i, ch_tx_data_i, ch_tx_strb_i, ch_tx_valid_i, ch_rx_ready_i,
               trans_phy_ready_i, tx_phy_ready_i, rx_phy_data_i, rx_phy_valid_i,
        input  ch_trans_ready_o, ch_tx_ready_o, ch_rx_data_o, ch_rx_valid_o,
               trans_phy_valid_o, trans_phy_address_o, trans_phy_cs_o, trans_phy_write_o,
               trans_phy_burst_o, tx_phy_data_o, tx_phy_strb_o, tx_phy_valid_o,
               rx_phy_ready_o, grant_o, busy_o, error_o
    );
endinterface

// File: rtl/hyperbus_trans_arbiter.sv
// Two-channel round-robin arbiter in front of one HyperBus PHY. A granted
// transaction keeps the PHY until its burst-length worth of data beats has
// been exchanged on the TX (write) or RX (read) stream.
// Optional idle-beat watchdog: define HYPER_ARB_TIMEOUT_EN.
module hyperbus_trans_arbiter #(
    parameter int unsigned TRANS_SIZE = 16
`ifdef HYPER_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    hyperbus_trans_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t                state_q, state_d;
    logic                  r_grant, r_last;
    logic [TRANS_SIZE-1:0] beat_cnt_q;
    logic [31:0]           addr_q;
    logic [1:0]            cs_q;
    logic                  write_q;
    logic [TRANS_SIZE-1:0] burst_q;

    logic                  sel, accept, beat_hs, burst_end, abort;
    logic [TRANS_SIZE-1:0] sel_burst;

`ifdef HYPER_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic [1:0]      err_q;
`endif

    // Request selection and beat handshake decode
    always_comb begin
        sel = 1'b0;
        unique case (bus.ch_trans_valid_i)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~r_last;
            default: sel = 1'b0;
        endcase
        // reset is folded in so no request is acknowledged while held in reset
        accept    = rst_ni && (state_q == IDLE) && (|bus.ch_trans_valid_i);
        sel_burst = sel ? bus.ch_trans_burst_i[2*TRANS_SIZE-1:TRANS_SIZE]
                        : bus.ch_trans_burst_i[TRANS_SIZE-1:0];
        beat_hs = 1'b0;
        if (state_q == DATA) begin
            if (write_q) beat_hs = (r_grant ? bus.ch_tx_valid_i[1] : bus.ch_tx_valid_i[0])
                                   & bus.tx_phy_ready_i;
            else         beat_hs = bus.rx_phy_valid_i
                                   & (r_grant ? bus.ch_rx_ready_i[1] : bus.ch_rx_ready_i[0]);
        end
        burst_end = beat_hs && (beat_cnt_q == TRANS_SIZE'(1));
`ifdef HYPER_ARB_TIMEOUT_EN
        abort = (state_q == DATA) && !beat_hs && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
        abort = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   if (bus.trans_phy_ready_i) state_d = (burst_q == '0) ? IDLE : DATA;
            DATA:    if (burst_end || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, round-robin history, latched transaction and beat counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            cs_q       <= '0;
            write_q    <= 1'b0;
            burst_q    <= '0;
        end else begin
            if (accept) begin
                r_grant <= sel;
                addr_q  <= sel ? bus.ch_trans_address_i[63:32] : bus.ch_trans_address_i[31:0];
                cs_q    <= sel ? bus.ch_trans_cs_i[3:2] : bus.ch_trans_cs_i[1:0];
                write_q <= bus.ch_trans_write_i[sel];
                burst_q <= sel_burst;
            end
            if (state_q == ISSUE && bus.trans_phy_ready_i) beat_cnt_q <= burst_q;
            else if (beat_hs)                              beat_cnt_q <= beat_cnt_q - TRANS_SIZE'(1);
            if (state_q != IDLE && state_d == IDLE) r_last <= r_grant;
        end
    end

`ifdef HYPER_ARB_TIMEOUT_EN
    // Idle-beat watchdog: counts DATA cycles since the last beat, pulses error on expiry
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            if (state_q != DATA || beat_hs) to_cnt_q <= '0;
            else                            to_cnt_q <= to_cnt_q + TO_W'(1);
            err_q <= '0;
            if (abort) err_q[r_grant] <= 1'b1;
        end
    end
    assign bus.error_o = err_q;
`else
    assign bus.error_o = '0;
`endif

    assign bus.trans_phy_address_o = addr_q;
    assign bus.trans_phy_cs_o      = cs_q;
    assign bus.trans_phy_write_o   = write_q;
    assign bus.trans_phy_burst_o   = burst_q;
    assign bus.grant_o             = r_grant;
    assign bus.busy_o              = (state_q != IDLE);

    // Handshake and data-path routing toward the granted channel
    always_comb begin
        bus.ch_trans_ready_o  = '0;
        bus.trans_phy_valid_o = 1'b0;
        bus.tx_phy_data_o     = '0;
        bus.tx_phy_strb_o     = '0;
        bus.tx_phy_valid_o    = 1'b0;
        bus.ch_tx_ready_o     = '0;
        bus.ch_rx_data_o      = '0;
        bus.ch_rx_valid_o     = '0;
        bus.rx_phy_ready_o    = 1'b0;
        if (accept) bus.ch_trans_ready_o[sel] = 1'b1;
        unique case (state_q)
            ISSUE: bus.trans_phy_valid_o = 1'b1;
            DATA: begin
                if (write_q) begin
                    bus.tx_phy_data_o  = r_grant ? bus.ch_tx_data_i[33:17] : bus.ch_tx_data_i[16:0];
                    bus.tx_phy_strb_o  = r_grant ? bus.ch_tx_strb_i[3:2] : bus.ch_tx_strb_i[1:0];
                    bus.tx_phy_valid_o = r_grant ? bus.ch_tx_valid_i[1] : bus.ch_tx_valid_i[0];
                    bus.ch_tx_ready_o[r_grant] = bus.tx_phy_ready_i;
                end else begin
                    bus.ch_rx_data_o           = bus.rx_phy_data_i;
                    bus.ch_rx_valid_o[r_grant] = bus.rx_phy_valid_i;
                    bus.rx_phy_ready_o         = r_grant ? bus.ch_rx_ready_i[1] : bus.ch_rx_ready_i[0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Directed + randomized bench for hyperbus_trans_arbiter. The reference is a
// transaction-level view: who wins (round-robin history), what gets issued,
// and how many beats each burst must move.
module tb_hyperbus_trans_arbiter;

    localparam int unsigned TS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hyperbus_trans_arbiter_if #(.TRANS_SIZE(TS)) bus();

    hyperbus_trans_arbiter #(
        .TRANS_SIZE(TS)
`ifdef HYPER_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int model_last = 1;   // channel served most recently

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int g);
        logic [1:0] r;
        r = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b11) return 1 - model_last;
        return v[1] ? 1 : 0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.ch_trans_valid_i   = '0;
        bus.ch_trans_address_i = '0;
        bus.ch_trans_cs_i      = '0;
        bus.ch_trans_write_i   = '0;
        bus.ch_trans_burst_i   = '0;
        bus.ch_tx_data_i       = '0;
        bus.ch_tx_strb_i       = '0;
        bus.ch_tx_valid_i      = '0;
        bus.ch_rx_ready_i      = '0;
        bus.trans_phy_ready_i  = 1'b0;
        bus.tx_phy_ready_i     = 1'b0;
        bus.rx_phy_data_i      = '0;
        bus.rx_phy_valid_i     = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trans_ready"}, 64'(bus.ch_trans_ready_o), 0);
        chk({tag, "_phy_valid"}, 64'(bus.trans_phy_valid_o), 0);
        chk({tag, "_addr"}, 64'(bus.trans_phy_address_o), 0);
        chk({tag, "_burst"}, 64'(bus.trans_phy_burst_o), 0);
        chk({tag, "_tx_valid"}, 64'(bus.tx_phy_valid_o), 0);
        chk({tag, "_rx_valid"}, 64'(bus.ch_rx_valid_o), 0);
        chk({tag, "_rx_ready"}, 64'(bus.rx_phy_ready_o), 0);
        chk({tag, "_ch_tx_ready"}, 64'(bus.ch_tx_ready_o), 0);
        chk({tag, "_grant"}, 64'(bus.grant_o), 0);
        chk({tag, "_busy"}, 64'(bus.busy_o), 0);
        chk({tag, "_error"}, 64'(bus.error_o), 0);
    endtask

    // One full transaction: request, ISSUE (optionally stalled), data beats.
    // wr/bl < 0 means random. Returns once the final beat handshake is driven;
    // the following cycle is expected to be IDLE again.
    task automatic run_txn(input logic [1:0] req, input int wr, input int bl, input int hold);
        logic [31:0]   a[2];
        logic [1:0]    cs[2];
        logic          w[2];
        logic [TS-1:0] b[2];
        int g, beats, cyc, streak;
        logic exp_v, hs;
        for (int c = 0; c < 2; c++) begin
            a[c]  = $urandom;
            cs[c] = 2'($urandom);
            w[c]  = (wr < 0) ? 1'($urandom) : 1'(wr);
            b[c]  = (bl < 0) ? TS'($urandom_range(0, 6)) : TS'(bl);
        end
        g = pick(req);

        tick();
        bus.ch_trans_valid_i   = req;
        bus.ch_trans_address_i = {a[1], a[0]};
        bus.ch_trans_cs_i      = {cs[1], cs[0]};
        bus.ch_trans_write_i   = {w[1], w[0]};
        bus.ch_trans_burst_i   = {b[1], b[0]};
        #1;
        chk("idle_busy", 64'(bus.busy_o), 0);
        chk("accept_ready", 64'(bus.ch_trans_ready_o), 64'(onehot(g)));
        chk("idle_tx_valid", 64'(bus.tx_phy_valid_o), 0);
        chk("idle_rx_valid", 64'(bus.ch_rx_valid_o), 0);

        for (int h = 0; h <= hold; h++) begin
            tick();
            bus.ch_trans_valid_i  = 2'($urandom);
            bus.trans_phy_ready_i = (h == hold);
            #1;
            chk("issue_valid", 64'(bus.trans_phy_valid_o), 1);
            chk("issue_addr", 64'(bus.trans_phy_address_o), 64'(a[g]));
            chk("issue_cs", 64'(bus.trans_phy_cs_o), 64'(cs[g]));
            chk("issue_write", 64'(bus.trans_phy_write_o), 64'(w[g]));
            chk("issue_burst", 64'(bus.trans_phy_burst_o), 64'(b[g]));
            chk("issue_grant", 64'(bus.grant_o), 64'(g));
            chk("issue_tx_valid", 64'(bus.tx_phy_valid_o), 0);
            chk("issue_rx_ready", 64'(bus.rx_phy_ready_o), 0);
            chk("issue_no_accept", 64'(bus.ch_trans_ready_o), 0);
        end

        beats = 0;
        cyc = 0;
        streak = 0;
        while (beats < int'(b[g]) && cyc < 200) begin
            tick();
            bus.trans_phy_ready_i = 1'($urandom);
            bus.ch_trans_valid_i  = 2'($urandom);
            bus.ch_tx_data_i      = 34'({$urandom, $urandom});
            bus.ch_tx_strb_i      = 4'($urandom);
            bus.ch_tx_valid_i     = 2'($urandom);
            bus.tx_phy_ready_i    = 1'($urandom);
            bus.rx_phy_data_i     = 17'($urandom);
            bus.rx_phy_valid_i    = 1'($urandom);
            bus.ch_rx_ready_i     = 2'($urandom);
            if (streak >= 4) begin
                bus.ch_tx_valid_i[g] = 1'b1;
                bus.tx_phy_ready_i   = 1'b1;
                bus.rx_phy_valid_i   = 1'b1;
                bus.ch_rx_ready_i[g] = 1'b1;
            end
            #1;
            chk("data_busy", 64'(bus.busy_o), 1);
            chk("data_no_accept", 64'(bus.ch_trans_ready_o), 0);
            chk("data_error", 64'(bus.error_o), 0);
            if (w[g]) begin
                exp_v = bus.ch_tx_valid_i[g];
                chk("wr_tx_valid", 64'(bus.tx_phy_valid_o), 64'(exp_v));
                if (exp_v) begin
                    chk("wr_tx_data", 64'(bus.tx_phy_data_o), 64'(bus.ch_tx_data_i[g*17 +: 17]));
                    chk("wr_tx_strb", 64'(bus.tx_phy_strb_o), 64'(bus.ch_tx_strb_i[g*2 +: 2]));
                end
                chk("wr_ch_tx_ready", 64'(bus.ch_tx_ready_o), bus.tx_phy_ready_i ? 64'(onehot(g)) : 0);
                chk("wr_rx_ready", 64'(bus.rx_phy_ready_o), 0);
                chk("wr_rx_valid", 64'(bus.ch_rx_valid_o), 0);
                hs = exp_v & bus.tx_phy_ready_i;
            end else begin
                exp_v = bus.rx_phy_valid_i;
                chk("rd_rx_valid", 64'(bus.ch_rx_valid_o), exp_v ? 64'(onehot(g)) : 0);
                chk("rd_rx_ready", 64'(bus.rx_phy_ready_o), 64'(bus.ch_rx_ready_i[g]));
                if (exp_v) chk("rd_rx_data", 64'(bus.ch_rx_data_o), 64'(bus.rx_phy_data_i));
                chk("rd_tx_valid", 64'(bus.tx_phy_valid_o), 0);
                chk("rd_ch_tx_ready", 64'(bus.ch_tx_ready_o), 0);
                hs = exp_v & bus.ch_rx_ready_i[g];
            end
            if (hs) begin
                beats++;
                streak = 0;
            end else begin
                streak++;
            end
            cyc++;
        end
        if (cyc >= 200) chk("beat_budget", 64'(beats), 64'(b[g]));
        model_last = g;
    endtask

    initial begin
        clear_inputs();
        bus.ch_trans_valid_i = 2'b11;
        tick();
        tick();
        #1;
        chk_all_zero("reset");

        tick();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        chk("post_reset_busy", 64'(bus.busy_o), 0);

        // tie from reset goes to ch0, then alternation
        run_txn(2'b11, 1, 4, 0);
        run_txn(2'b11, -1, -1, 0);
        run_txn(2'b11, -1, -1, 0);
        // ch1 read, 3 beats
        run_txn(2'b10, 0, 3, 0);
        // zero-length burst, then immediate next request
        run_txn(2'b01, -1, 0, 0);
        run_txn(2'b10, -1, -1, 0);
        // PHY stalls the issue for 5 cycles
        run_txn(2'b11, 0, 2, 5);
        for (int i = 0; i < 12; i++)
            run_txn(2'($urandom_range(1, 3)), -1, -1, $urandom_range(0, 3));

`ifdef HYPER_ARB_TIMEOUT_EN
        // write with no TX data: watchdog aborts after 8 idle DATA cycles
        begin
            int g;
            g = pick(2'b01);
            tick();
            clear_inputs();
            bus.ch_trans_valid_i = 2'b01;
            bus.ch_trans_write_i = 2'b01;
            bus.ch_trans_burst_i = {TS'(0), TS'(3)};
            #1;
            chk("to_accept", 64'(bus.ch_trans_ready_o), 64'(onehot(g)));
            tick();
            bus.ch_trans_valid_i  = '0;
            bus.trans_phy_ready_i = 1'b1;
            #1;
            chk("to_issue", 64'(bus.trans_phy_valid_o), 1);
            for (int i = 0; i < 8; i++) begin
                tick();
                #1;
                chk("to_wait_busy", 64'(bus.busy_o), 1);
                chk("to_wait_error", 64'(bus.error_o), 0);
            end
            tick();
            #1;
            chk("to_abort_busy", 64'(bus.busy_o), 0);
            chk("to_abort_error", 64'(bus.error_o), 64'(onehot(g)));
            tick();
            #1;
            chk("to_error_pulse", 64'(bus.error_o), 0);
            model_last = g;
        end
`endif

        // reset in the middle of a burst
        tick();
        clear_inputs();
        bus.ch_trans_valid_i = 2'b10;
        bus.ch_trans_write_i = 2'b10;
        bus.ch_trans_burst_i = {TS'(5), TS'(0)};
        tick();
        bus.ch_trans_valid_i  = '0;
        bus.trans_phy_ready_i = 1'b1;
        tick();
        #1;
        chk("mid_busy", 64'(bus.busy_o), 1);
        tick();
        rst_n = 1'b0;
        bus.ch_trans_valid_i = 2'b11;
        bus.ch_tx_valid_i    = 2'b11;
        bus.tx_phy_ready_i   = 1'b1;
        tick();
        #1;
        chk_all_zero("mid_reset");
        model_last = 1;
        tick();
        rst_n = 1'b1;
        clear_inputs();

        run_txn(2'b11, -1, -1, 0);
        tick();
        clear_inputs();
        #1;
        chk("final_busy", 64'(bus.busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/hyperbus_trans_arbiter.md
Name: hyperbus_trans_arbiter

Overview:
Two-channel arbiter sharing one HyperBus PHY transaction port and its TX/RX 16-bit data streams between two uDMA-side transaction controllers (channel 0 and channel 1).
- Accepts one transaction at a time, then holds the grant until every data beat of the burst has been exchanged.
- Routes the TX and RX streams to and from the granted channel only.
- Sits between the per-channel transaction controllers and the single PHY.

Parameters:
TRANS_SIZE, 16, width of the burst length field, in 16-bit words.
TIMEOUT_CYCLES, 1024, idle-beat watchdog limit. Used only when HYPER_ARB_TIMEOUT_EN is defined.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous active-low
ch_trans_valid_i  in  2  per-channel transaction request
ch_trans_ready_o  out  2  per-channel transaction accept
ch_trans_address_i  in  64  {ch1,ch0} word address, 32b each
ch_trans_cs_i  in  4  {ch1,ch0} chip select, 2b each
ch_trans_write_i  in  2  1 = write, 0 = read
ch_trans_burst_i  in  2*TRANS_SIZE  {ch1,ch0} burst length in words
ch_tx_data_i  in  34  {ch1,ch0} {last, data[15:0]}
ch_tx_strb_i  in  4  {ch1,ch0} byte strobes
ch_tx_valid_i  in  2  per-channel TX valid
ch_tx_ready_o  out  2  per-channel TX ready
ch_rx_data_o  out  17  RX data broadcast to both channels
ch_rx_valid_o  out  2  RX valid, granted channel only
ch_rx_ready_i  in  2  per-channel RX ready
trans_phy_valid_o  out  1  PHY transaction valid
trans_phy_ready_i  in  1  PHY transaction ready
trans_phy_address_o  out  32  latched address
trans_phy_cs_o  out  2  latched chip select
trans_phy_write_o  out  1  latched write flag
trans_phy_burst_o  out  TRANS_SIZE  latched burst length
tx_phy_data_o  out  17  TX data to PHY
tx_phy_strb_o  out  2  TX strobes to PHY
tx_phy_valid_o  out  1  TX valid to PHY
tx_phy_ready_i  in  1  TX ready from PHY
rx_phy_data_i  in  17  RX data from PHY
rx_phy_valid_i  in  1  RX valid from PHY
rx_phy_ready_o  out  1  RX ready to PHY
grant_o  out  1  granted channel index
busy_o  out  1  1 whenever state is not IDLE
error_o  out  2  per-channel timeout-abort pulse

Behaviour:
- State machine: IDLE, ISSUE, DATA. On reset: state IDLE, r_grant = 0, r_last = 1 (so ch0 wins the first tie), beat counter 0, latched transaction fields 0.
- Reset values of outputs: all outputs 0.
- IDLE, request selection:
  - Only one channel valid: that channel is selected.
  - Both valid: select ~r_last (round-robin).
- IDLE, acceptance:
  - ch_trans_ready_o[sel] = 1 combinationally in the same cycle.
  - Address, cs, write and burst are latched.
  - r_grant = sel; next state ISSUE.
  - The non-selected channel's ready stays 0.
- ISSUE:
  - trans_phy_valid_o = 1 with the latched fields; these are stable while valid is high.
  - On trans_phy_ready_i: beat counter loads burst. Next state is DATA if burst != 0. If burst == 0, next state is IDLE and r_last = r_grant.
- DATA, write transaction:
  - tx_phy_* are driven from channel r_grant.
  - ch_tx_ready_o[r_grant] = tx_phy_ready_i; ch_tx_ready_o of the other channel = 0.
  - rx_phy_ready_o = 0.
- DATA, read transaction:
  - ch_rx_valid_o[r_grant] = rx_phy_valid_i; rx_phy_ready_o = ch_rx_ready_i[r_grant].
  - ch_rx_data_o = rx_phy_data_i.
  - tx_phy_valid_o = 0.
- Beat counting:
  - The counter decrements on each beat handshake (valid & ready on the active path).
  - The handshake with counter == 1 ends the burst: next state IDLE, r_last = r_grant.
  - The last flag in data bit 16 is passed through but is not used to end the burst.
- Outside DATA: all data-path valid and ready outputs are 0.
- New request arriving in the cycle a burst completes: not accepted until the following cycle, when IDLE is re-entered. Latency from request to PHY issue is 1 cycle.
- Requester dropping ch_trans_valid_i: a requester must not drop valid before acceptance. If it does while in IDLE, the request is simply not taken.
- Reset mid-burst: immediate return to reset values; no completion is signalled.

Optional Feature:
HYPER_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter runs in DATA and clears on every beat handshake.
  - When it reaches TIMEOUT_CYCLES: abort to IDLE, pulse error_o[r_grant] for 1 cycle, set r_last = r_grant.
  - The counter also clears on entry to DATA.
- Undefined: no counter is implemented; error_o is tied to 0.

Test Plan:
- ch0 write, burst = 4, PHY ready held high -> ch_trans_ready_o = 2'b01 in the request cycle; trans_phy_valid_o 1 cycle later with address/burst = 4; 4 TX beats forwarded; busy_o = 0 on the cycle after beat 4.
- Both channels request from reset -> ch0 granted first; after its burst ch1 granted; both again -> ch0 (alternation).
- ch1 read, burst = 3, PHY RX valid with ch_rx_ready_i[1] toggling -> exactly 3 beats delivered to ch1 only; ch_rx_valid_o[0] stays 0.
- Burst = 0 request -> ISSUE then IDLE with no data-path activity; the next request is accepted 1 cycle later.
- trans_phy_ready_i held 0 for 5 cycles in ISSUE -> trans_phy_valid_o held with stable fields; rx_phy_ready_o = 0 and tx_phy_valid_o = 0 throughout.
- HYPER_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, write with no TX valid -> error_o[grant] pulses once after 8 idle cycles, state returns to IDLE; rst_ni low mid-burst clears all outputs on the next edge.
